frame_receiver: RTL and testbench
=================================

// Module: frame_receiver
// PURPOSE
//  Decodes a single-wire WS2812-style NRZ stream (LED-chain DOUT, or transmitter loopback) into 24-bit frames.
//  Bit value comes from measured high-pulse width; the low-gap reset/latch code separates frame sets.
//  Counterpart of the frame transmitter. Used for loopback self-test and chain monitoring.
// PARAMETERS
//  BIT_THRESH_CYC  30    high width >= this -> bit 1, else bit 0 (50 MHz: T0H=20, T1H=40)
//  MIN_HIGH_CYC    8     high width < this -> runt pulse, bit_error
//  MAX_HIGH_CYC    60    high width > this -> stuck-high, bit_error
//  RESET_CYC       2500  low width >= this -> latch/reset gap (50 us @ 50 MHz)
//  FRAMES_PER_SET  8     frames per set; frame_idx wraps here
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous reset, active high
//  din             in   1   serial LED data line, asynchronous to clk
//  frame_data      out  24  last complete frame, MSB = first bit received
//  frame_valid     out  1   1-cycle pulse: frame_data updated
//  frame_idx       out  3   index of frame in frame_data (0..FRAMES_PER_SET-1)
//  set_done        out  1   1-cycle pulse coincident with frame_valid of the last frame in a set
//  latch_det       out  1   1-cycle pulse when a reset gap completes
//  bit_error       out  1   1-cycle pulse on runt/stuck-high pulse or partial frame at gap
//  busy            out  1   high while a frame is partly received (bit_cnt != 0)
// BEHAVIOUR
//  Reset: all outputs 0; frame_data=24'h0; bit_cnt=0; frame_idx=0; FSM=WAIT_GAP.
//  din passes through a 2-FF synchroniser. Edges are detected on the synchronised signal, one register later.
//  Counters: high_cnt 8 bit, low_cnt 12 bit. Both saturate and never wrap.
//  FSM:
//   WAIT_GAP: count low cycles; any high restarts the count. At low_cnt==RESET_CYC -> IDLE, pulse latch_det.
//             A mid-stream join is therefore ignored until the first gap.
//   IDLE:  rising edge -> HIGH, high_cnt=1.
//   HIGH:  high_cnt++. Above MAX_HIGH_CYC -> bit_error, discard partial frame, bit_cnt=0, -> WAIT_GAP.
//          Falling edge, high_cnt<MIN_HIGH_CYC -> bit_error, discard frame, -> WAIT_GAP.
//          Falling edge, otherwise -> shift bit (high_cnt>=BIT_THRESH_CYC) into shreg LSB, bit_cnt++, -> LOW, low_cnt=1.
//   LOW:   low_cnt++. Rising edge before RESET_CYC -> HIGH, high_cnt=1.
//          low_cnt==RESET_CYC -> latch_det pulse, frame_idx=0, -> IDLE.
//          If bit_cnt!=0 at the gap, also pulse bit_error and clear bit_cnt.
//  Frame completion: the shift making bit_cnt==24 sets frame_data=shreg and pulses frame_valid.
//   It also sets frame_idx to the current count, clears bit_cnt, and advances the count.
//   frame_valid rises exactly 3 clk after the din falling edge of bit 23.
//  Set: frame_idx counts 0..FRAMES_PER_SET-1. The frame with idx==FRAMES_PER_SET-1 also pulses set_done.
//   The count then wraps to 0. More frames than that before a gap wrap silently.
//  A gap resets the frame count to 0 even mid-set. No set_done is given for a short set.
//  Rising edge on the same cycle low_cnt reaches RESET_CYC: the gap wins, then the edge is treated as a new bit from IDLE.
//  frame_data holds its value until the next complete frame. It is never cleared by an error.
//  rst asserted mid-frame: immediate return to reset state. The partial frame is lost; no pulses are emitted.
// CONFIGURATION
//  FRAME_RX_GLITCH_FILTER_EN defined:
//   din passes a stability filter after the synchroniser.
//   A level change is accepted only after 2 consecutive equal samples. Single-cycle glitches are removed.
//   All widths are measured on the filtered signal. frame_valid latency becomes 5 clk.
//  Undefined: no filter, latency 3 clk. A 1-cycle glitch is a runt pulse -> bit_error.
// TESTING
//  1. Reset, din low 2500 cyc -> latch_det pulse once, frame_idx=0, no other pulse.
//  2. Gap, then 24 bits of 24'hA5C3F0 (1: 40H/22L, 0: 20H/42L)
//     -> frame_valid 3 clk after last fall, frame_data=24'hA5C3F0, frame_idx=0.
//  3. Gap, then 8 frames 24'h000001..24'h000008 back to back
//     -> frame_idx 0..7; set_done with frame 8 only; next gap -> latch_det.
//  4. Gap, 10 bits, then 2500 low -> bit_error and latch_det same cycle; busy 1->0.
//     Next 24-bit frame decodes correctly with idx 0.
//  5. 5-cycle high pulse mid-frame -> bit_error; frame discarded; frames ignored until next gap.
//     With FRAME_RX_GLITCH_FILTER_EN: 1-cycle glitch during low is ignored, no error.
//  6. Start stream without a preceding gap (din high at rst release) -> no frame_valid until first gap.
//     rst pulsed at bit 12 -> outputs 0, FSM back in WAIT_GAP.

Source files
------------

// File: rtl/frame_receiver.sv
// WS2812-style NRZ receiver: high-pulse width decodes each bit, a long low gap latches/resets the set.
// Optional FRAME_RX_GLITCH_FILTER_EN adds a 2-sample stability filter after the synchroniser.
module frame_receiver #(
  parameter int unsigned BIT_THRESH_CYC = 30,
  parameter int unsigned MIN_HIGH_CYC   = 8,
  parameter int unsigned MAX_HIGH_CYC   = 60,
  parameter int unsigned RESET_CYC      = 2500,
  parameter int unsigned FRAMES_PER_SET = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] frame_data,
  output logic        frame_valid,
  output logic [2:0]  frame_idx,
  output logic        set_done,
  output logic        latch_det,
  output logic        bit_error,
  output logic        busy
);

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  localparam logic [7:0]  THRESH   = 8'(BIT_THRESH_CYC);
  localparam logic [7:0]  MIN_HIGH = 8'(MIN_HIGH_CYC);
  localparam logic [7:0]  MAX_HIGH = 8'(MAX_HIGH_CYC);
  localparam logic [11:0] GAP_LEN  = 12'(RESET_CYC);
  localparam logic [2:0]  LAST_IDX = 3'(FRAMES_PER_SET - 1);

  state_t      state, state_n;
  logic        sync1, sync2, lvl, lvl_d, rise, fall;
  logic [7:0]  high_cnt, high_cnt_n, high_inc;
  logic [11:0] low_cnt, low_cnt_n, low_inc;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [22:0] shreg, shreg_n;
  logic [23:0] shift_word, data_n;
  logic [2:0]  set_cnt, set_cnt_n, idx_n;
  logic        fv_n, sd_n, ld_n, be_n, gap, bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

`ifdef FRAME_RX_GLITCH_FILTER_EN
  logic sync2_d, filt;

  // Level follows sync2 only once two consecutive samples agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync2_d <= 1'b0;
      filt    <= 1'b0;
    end else begin
      sync2_d <= sync2;
      if (sync2 == sync2_d && sync2 != filt) filt <= sync2;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= lvl;
  end

  assign rise       = lvl & ~lvl_d;
  assign fall       = ~lvl & lvl_d;
  assign high_inc   = (high_cnt == '1) ? high_cnt : high_cnt + 8'd1;
  assign low_inc    = (low_cnt == '1) ? low_cnt : low_cnt + 12'd1;
  assign bit_val    = (high_cnt >= THRESH);
  assign shift_word = {shreg, bit_val};
  assign gap        = (state == WAIT_GAP || state == LOW) && (low_cnt == GAP_LEN);
  assign busy       = (bit_cnt != '0);

  always_comb begin
    state_n    = state;
    high_cnt_n = high_cnt;
    low_cnt_n  = low_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    set_cnt_n  = set_cnt;
    data_n     = frame_data;
    idx_n      = frame_idx;
    fv_n       = 1'b0;
    sd_n       = 1'b0;
    ld_n       = 1'b0;
    be_n       = 1'b0;
    if (gap) begin
      // Gap takes priority; a coincident rising edge then starts a bit from IDLE.
      ld_n      = 1'b1;
      be_n      = (bit_cnt != '0);
      bit_cnt_n = '0;
      set_cnt_n = '0;
      idx_n     = '0;
      low_cnt_n = '0;
      state_n   = IDLE;
      if (rise) begin
        state_n    = HIGH;
        high_cnt_n = 8'd1;
      end
    end else begin
      case (state)
        WAIT_GAP: low_cnt_n = lvl ? '0 : low_inc;
        IDLE: begin
          if (rise) begin
            state_n    = HIGH;
            high_cnt_n = 8'd1;
          end
        end
        HIGH: begin
          if (fall) begin
            if (high_cnt < MIN_HIGH) begin
              be_n      = 1'b1;
              bit_cnt_n = '0;
              low_cnt_n = 12'd1;
              state_n   = WAIT_GAP;
            end else begin
              shreg_n = shift_word[22:0];
              if (bit_cnt == 5'd23) begin
                data_n    = shift_word;
                fv_n      = 1'b1;
                idx_n     = set_cnt;
                sd_n      = (set_cnt == LAST_IDX);
                set_cnt_n = (set_cnt == LAST_IDX) ? '0 : set_cnt + 3'd1;
                bit_cnt_n = '0;
              end else begin
                bit_cnt_n = bit_cnt + 5'd1;
              end
              low_cnt_n = 12'd1;
              state_n   = LOW;
            end
          end else if (high_cnt >= MAX_HIGH) begin
            be_n      = 1'b1;
            bit_cnt_n = '0;
            low_cnt_n = '0;
            state_n   = WAIT_GAP;
          end else begin
            high_cnt_n = high_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state_n    = HIGH;
            high_cnt_n = 8'd1;
          end else begin
            low_cnt_n = low_inc;
          end
        end
        default: state_n = WAIT_GAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_GAP;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      set_cnt     <= '0;
      frame_data  <= '0;
      frame_idx   <= '0;
      frame_valid <= 1'b0;
      set_done    <= 1'b0;
      latch_det   <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      state       <= state_n;
      high_cnt    <= high_cnt_n;
      low_cnt     <= low_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      set_cnt     <= set_cnt_n;
      frame_data  <= data_n;
      frame_idx   <= idx_n;
      frame_valid <= fv_n;
      set_done    <= sd_n;
      latch_det   <= ld_n;
      bit_error   <= be_n;
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Bench for frame_receiver: pulse-level model predicts output pulses per cycle from segment widths.
module tb_frame_receiver;

  localparam int THR = 30, MINH = 8, MAXH = 60, R = 2500, F = 8;
`ifdef FRAME_RX_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0, rst = 1'b1, din = 1'b0;
  logic [23:0] frame_data;
  logic        frame_valid, set_done, latch_det, bit_error, busy;
  logic [2:0]  frame_idx;

  frame_receiver #(.BIT_THRESH_CYC(THR), .MIN_HIGH_CYC(MINH), .MAX_HIGH_CYC(MAXH),
                   .RESET_CYC(R), .FRAMES_PER_SET(F)) dut (
    .clk(clk), .rst(rst), .din(din), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_idx(frame_idx), .set_done(set_done), .latch_det(latch_det),
    .bit_error(bit_error), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected events keyed by the cycle count at which they must be visible.
  bit          exp_fv[int], exp_sd[int], exp_ld[int], exp_be[int];
  logic [23:0] exp_data[int];
  logic [2:0]  exp_idx[int];

  bit          synced = 0, post_rst = 0;
  logic [23:0] msh = '0;
  int          nb = 0, setc = 0;

  function automatic void model_high(int kr, int w);
    if (!synced) return;
    if (w > MAXH) begin
      exp_be[kr + MAXH + LAT] = 1; synced = 0; nb = 0;
    end else if (w < MINH) begin
      exp_be[kr + w + LAT] = 1; synced = 0; nb = 0;
    end else begin
      msh = {msh[22:0], (w >= THR)};
      nb++;
      if (nb == 24) begin
        exp_fv[kr + w + LAT]   = 1;
        exp_data[kr + w + LAT] = msh;
        exp_idx[kr + w + LAT]  = 3'(setc);
        exp_sd[kr + w + LAT]   = (setc == F - 1);
        setc = (setc + 1) % F;
        nb = 0;
      end
    end
  endfunction

  function automatic void model_low(int kf, int w);
    if (w < R) return;
    exp_ld[kf + R + LAT] = 1;
    if (synced && nb != 0) exp_be[kf + R + LAT] = 1;
    nb = 0; setc = 0; synced = 1;
  endfunction

  // Compare process plus pulse monitors feeding the directed checks.
  logic [23:0] mdata = '0;
  logic [2:0]  midx = '0;
  int n_fv = 0, n_sd = 0, n_ld = 0, n_be = 0;
  int last_fv = -1, last_sd = -2, last_ld = -3, last_be = -4;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      check("rst_frame_data", frame_data, 0);
      check("rst_pulses", {frame_valid, set_done, latch_det, bit_error, busy}, 0);
      check("rst_frame_idx", frame_idx, 0);
    end else begin
      if (exp_fv.exists(cyc)) begin mdata = exp_data[cyc]; midx = exp_idx[cyc]; end
      if (exp_ld.exists(cyc)) midx = '0;
      check("frame_valid", frame_valid, exp_fv.exists(cyc));
      check("set_done", set_done, exp_sd.exists(cyc) ? exp_sd[cyc] : 1'b0);
      check("latch_det", latch_det, exp_ld.exists(cyc));
      check("bit_error", bit_error, exp_be.exists(cyc));
      check("frame_data", frame_data, mdata);
      check("frame_idx", frame_idx, midx);
      if (frame_valid) begin n_fv++; last_fv = cyc; end
      if (set_done)    begin n_sd++; last_sd = cyc; end
      if (latch_det)   begin n_ld++; last_ld = cyc; end
      if (bit_error)   begin n_be++; last_be = cyc; end
    end
  end

  task automatic do_reset(logic lvl);
    din = lvl;
    rst = 1'b1;
    exp_fv.delete(); exp_sd.delete(); exp_ld.delete(); exp_be.delete();
    exp_data.delete(); exp_idx.delete();
    mdata = '0; midx = '0; synced = 0; nb = 0; setc = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    post_rst = 1;
  endtask

  task automatic seg_hi(int w);
    din = 1'b1;
    post_rst = 0;
    model_high(cyc, w);
    repeat (w) @(negedge clk);
  endtask

  task automatic seg_lo(int w);
    int kf;
    kf = post_rst ? cyc - (LAT - 1) : cyc;
    post_rst = 0;
    din = 1'b0;
    model_low(kf, w + cyc - kf);
    repeat (w) @(negedge clk);
  endtask

  task automatic glitch_lo(int w);
`ifdef FRAME_RX_GLITCH_FILTER_EN
    model_low(cyc, w);
`else
    model_low(cyc, 20);
    model_high(cyc + 20, 1);
    model_low(cyc + 21, w - 21);
`endif
    din = 1'b0; repeat (20) @(negedge clk);
    din = 1'b1; @(negedge clk);
    din = 1'b0; repeat (w - 21) @(negedge clk);
  endtask

  int last_fall = 0;
  // Sends d[n-1:0] MSB first; last_lo==0 leaves the final low to the caller.
  task automatic send_word(logic [23:0] d, int n, int last_lo, int runt_at, int glitch_at);
    for (int i = 0; i < n; i++) begin
      logic b;
      int   h, l;
      b = d[n - 1 - i];
      h = b ? 40 : 20;
      l = (i == n - 1) ? last_lo : (b ? 22 : 42);
      if (i == runt_at) h = 5;
      if (i == n - 1) last_fall = cyc + h;
      seg_hi(h);
      if (l != 0) begin
        if (i == glitch_at) glitch_lo(l);
        else seg_lo(l);
      end
    end
  endtask

  int b_fv, b_sd, b_ld, b_be;
  task automatic snap();
    b_fv = n_fv; b_sd = n_sd; b_ld = n_ld; b_be = n_be;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // 1: gap after reset
    do_reset(1'b0);
    snap();
    seg_lo(2600);
    check("t1_latch_count", n_ld - b_ld, 1);
    check("t1_other_pulses", (n_fv - b_fv) + (n_be - b_be), 0);
    check("t1_frame_idx", frame_idx, 0);

    // 2: single frame
    snap();
    send_word(24'hA5C3F0, 24, 2600, -1, -1);
    check("t2_frame_data", frame_data, 24'hA5C3F0);
    check("t2_frame_idx", frame_idx, 0);
    check("t2_latency", last_fv - last_fall, LAT);
    check("t2_fv_count", n_fv - b_fv, 1);

    // 3: full set of 8 frames
    snap();
    for (int f = 1; f <= 8; f++) send_word(24'(f), 24, (f == 8) ? 2600 : 42, -1, -1);
    check("t3_fv_count", n_fv - b_fv, 8);
    check("t3_sd_count", n_sd - b_sd, 1);
    check("t3_sd_with_last", last_sd, last_fv);
    check("t3_frame_data", frame_data, 24'h000008);
    check("t3_latch_count", n_ld - b_ld, 1);

    // 4: partial frame at gap
    snap();
    send_word(24'h0002CE, 10, 0, -1, -1);
    din = 1'b0;
    model_low(cyc, 2600);
    repeat (LAT + 2) @(negedge clk);
    check("t4_busy_partial", busy, 1);
    repeat (2600 - LAT - 2) @(negedge clk);
    check("t4_busy_after_gap", busy, 0);
    check("t4_err_count", n_be - b_be, 1);
    check("t4_err_with_latch", last_be, last_ld);
    send_word(24'h123456, 24, 2600, -1, -1);
    check("t4_next_data", frame_data, 24'h123456);
    check("t4_next_idx", frame_idx, 0);

    // 5: runt mid-frame, ignored frame, stuck high, recovery, 1-cycle glitch
    snap();
    send_word(24'h5A5A5A, 24, 42, 5, -1);
    send_word(24'h777777, 24, 2600, -1, -1);
    check("t5_runt_err", n_be - b_be, 1);
    check("t5_no_frame", n_fv - b_fv, 0);
    snap();
    seg_hi(70);
    seg_lo(2600);
    check("t5_stuck_err", n_be - b_be, 1);
    send_word(24'h0F0F0F, 24, 2600, -1, -1);
    check("t5_recover_data", frame_data, 24'h0F0F0F);
    snap();
    send_word(24'h3C3C3C, 24, 2600, -1, 1);
`ifdef FRAME_RX_GLITCH_FILTER_EN
    check("t5_glitch_err", n_be - b_be, 0);
    check("t5_glitch_frame", frame_data, 24'h3C3C3C);
`else
    check("t5_glitch_err", n_be - b_be, 1);
    check("t5_glitch_frame", frame_data, 24'h0F0F0F);
`endif

    // 6: join mid-stream, then reset mid-frame
    snap();
    do_reset(1'b1);
    seg_hi(30);
    seg_lo(42);
    send_word(24'h111111, 24, 2600, -1, -1);
    check("t6_join_no_frame", n_fv - b_fv, 0);
    check("t6_join_latch", n_ld - b_ld, 1);
    send_word(24'h000ABC, 12, 10, -1, -1);
    check("t6_busy_mid", busy, 1);
    do_reset(1'b0);
    check("t6_rst_data", frame_data, 0);
    check("t6_rst_busy", busy, 0);
    snap();
    seg_lo(100);
    send_word(24'hFFFFFF, 24, 2600, -1, -1);
    check("t6_wait_gap_ignored", n_fv - b_fv, 0);
    send_word(24'hABCDEF, 24, 2600, -1, -1);
    check("t6_final_data", frame_data, 24'hABCDEF);
    check("t6_final_idx", frame_idx, 0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
